tmdsdecode: RTL and testbench

- Per-channel TMDS receive decoder for the HDMI path.
- Takes one word-aligned 10-bit TMDS symbol per clock and tracks the HDMI period sequence: control, preamble, guard, video, data island.
- Outputs the period type, control bits, TERC4 nibble or pixel byte, with error and lock flags.
- Inverse of the channel encoder. Word alignment, clock recovery and the channel-to-channel deskew happen upstream.

---
 rtl/tmdsdecode.sv | 260 ++++++++++++++++++++++++++
 tb/tb_tmdsdecode.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tmdsdecode.sv
// tmdsdecode: per-channel TMDS receive decoder.
// Stage 1 bit-reverses the incoming symbol and classifies it (control, guard, TERC4).
// Stage 2 runs the HDMI period FSM, decodes the fields and tracks lock.
// Fields that are not valid for the reported period type are driven to zero.
module tmdsdecode #(
  parameter logic [1:0]  CHANNEL    = 2'b00,
  parameter logic [1:0]  VID_PRE    = 2'b01,
  parameter logic [1:0]  ISL_PRE    = 2'b11,
  parameter int unsigned PRE_MIN    = 8,
  parameter int unsigned ISLAND_LEN = 32,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned ERR_LIMIT  = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [9:0] i_word,
  output logic [1:0] o_dtype,
  output logic [1:0] o_ctl,
  output logic [3:0] o_aux,
  output logic [7:0] o_data,
  output logic       o_err,
  output logic       o_locked
);

  localparam logic [9:0] GUARD_WORD = (CHANNEL == 2'b01) ? 10'b0100110011 : 10'b1011001100;
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam int ECW = $clog2(ERR_LIMIT + 1);
  localparam logic [4:0]     PRE_MIN_W = 5'(PRE_MIN);
  localparam logic [5:0]     ISL_LAST  = 6'(ISLAND_LEN - 1);
  localparam logic [LCW-1:0] LOCK_W    = LCW'(LOCK_CNT);
  localparam logic [LCW-1:0] LCNT_ONE  = LCW'(1);
  localparam logic [ECW-1:0] ERR_W     = ECW'(ERR_LIMIT);
  localparam logic [ECW-1:0] ECNT_ONE  = ECW'(1);

  localparam logic [1:0] DT_GUARD = 2'b00;
  localparam logic [1:0] DT_CTRL  = 2'b01;
  localparam logic [1:0] DT_ISL   = 2'b10;
  localparam logic [1:0] DT_PIX   = 2'b11;

  typedef enum logic [2:0] {
    ST_CONTROL = 3'd0, ST_VGUARD = 3'd1, ST_VIDEO = 3'd2,
    ST_IGUARD  = 3'd3, ST_ISLAND = 3'd4, ST_ITRAIL = 3'd5
  } state_t;

  // {valid, code} for the four control tokens
  function automatic logic [2:0] ctrl_decode(input logic [9:0] w);
    case (w)
      10'h354: ctrl_decode = 3'b100;
      10'h0AB: ctrl_decode = 3'b101;
      10'h154: ctrl_decode = 3'b110;
      10'h2AB: ctrl_decode = 3'b111;
      default: ctrl_decode = 3'b000;
    endcase
  endfunction

  // {valid, nibble}: inverse of the TERC4 encoder table
  function automatic logic [4:0] terc4_decode(input logic [9:0] w);
    case (w)
      10'h29C: terc4_decode = 5'h10;
      10'h263: terc4_decode = 5'h11;
      10'h2E4: terc4_decode = 5'h12;
      10'h2E2: terc4_decode = 5'h13;
      10'h171: terc4_decode = 5'h14;
      10'h11E: terc4_decode = 5'h15;
      10'h18E: terc4_decode = 5'h16;
      10'h13C: terc4_decode = 5'h17;
      10'h2CC: terc4_decode = 5'h18;
      10'h139: terc4_decode = 5'h19;
      10'h19C: terc4_decode = 5'h1A;
      10'h2C6: terc4_decode = 5'h1B;
      10'h28E: terc4_decode = 5'h1C;
      10'h271: terc4_decode = 5'h1D;
      10'h163: terc4_decode = 5'h1E;
      10'h2C3: terc4_decode = 5'h1F;
      default: terc4_decode = 5'h00;
    endcase
  endfunction

  // Undo the optional inversion (w[9]) and the XOR/XNOR chain (w[8] selects XOR)
  function automatic logic [7:0] pixel_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d    = 8'h00;
    d[0] = q[0];
    for (int k = 1; k < 8; k++) begin
      d[k] = w[8] ? (q[k] ^ q[k-1]) : ~(q[k] ^ q[k-1]);
    end
    return d;
  endfunction

  // Stage 1 state
  logic [9:0] w_d, w_q;
  logic       v_d, v_q;
  logic       is_ctrl_d, is_ctrl_q;
  logic [1:0] ctrl_code_d, ctrl_code_q;
  logic       is_guard_d, is_guard_q;
  logic       is_terc4_d, is_terc4_q;
  logic [3:0] nib_d, nib_q;
  logic [2:0] ctl_s;
  logic [4:0] ter_s;

  // Stage 2 state
  state_t         state_d, state_q;
  logic [4:0]     run_d, run_q;
  logic [1:0]     last_d, last_q;
  logic [5:0]     icnt_d, icnt_q;
  logic [1:0]     tcnt_d, tcnt_q;
  logic [1:0]     dtype_d, dtype_q;
  logic [1:0]     ctl_d, ctl_q;
  logic [3:0]     aux_d, aux_q;
  logic [7:0]     data_d, data_q;
  logic           err_d, err_q;
  logic [LCW-1:0] ccnt_d, ccnt_q;
  logic [ECW-1:0] ecnt_d, ecnt_q;
  logic           locked_d, locked_q;
  logic           ctl_out_s;

  // Stage 1: bit-reverse the symbol and classify it
  always_comb begin
    w_d = 10'h000;
    for (int k = 0; k < 10; k++) begin
      w_d[k] = i_word[9 - k];
    end
    ctl_s       = ctrl_decode(w_d);
    ter_s       = terc4_decode(w_d);
    v_d         = 1'b1;
    is_ctrl_d   = ctl_s[2];
    ctrl_code_d = ctl_s[1:0];
    is_guard_d  = (w_d == GUARD_WORD);
    is_terc4_d  = ter_s[4];
    nib_d       = ter_s[3:0];
  end

  // Stage 1 registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      w_q <= 10'h000; v_q <= 1'b0; is_ctrl_q <= 1'b0; ctrl_code_q <= 2'b00;
      is_guard_q <= 1'b0; is_terc4_q <= 1'b0; nib_q <= 4'h0;
    end else begin
      w_q <= w_d; v_q <= v_d; is_ctrl_q <= is_ctrl_d; ctrl_code_q <= ctrl_code_d;
      is_guard_q <= is_guard_d; is_terc4_q <= is_terc4_d; nib_q <= nib_d;
    end
  end

  // Stage 2: period FSM next state, field decode, preamble run and lock tracking
  always_comb begin
    state_d = state_q; run_d = run_q; last_d = last_q; icnt_d = icnt_q; tcnt_d = tcnt_q;
    dtype_d = dtype_q; ctl_d = ctl_q; aux_d = aux_q; data_d = data_q; err_d = err_q;
    ccnt_d = ccnt_q; ecnt_d = ecnt_q; locked_d = locked_q;
    ctl_out_s = 1'b0;
    if (v_q) begin
      dtype_d = DT_CTRL; ctl_d = 2'b00; aux_d = 4'h0; data_d = 8'h00; err_d = 1'b0;
      case (state_q)
        ST_CONTROL: begin
          if (is_ctrl_q) begin
            ctl_out_s = 1'b1;
          end else if (is_guard_q && (run_q >= PRE_MIN_W) && (last_q == VID_PRE)) begin
            dtype_d = DT_GUARD; state_d = ST_VGUARD;
          end else if (is_guard_q && (run_q >= PRE_MIN_W) && (last_q == ISL_PRE)) begin
            dtype_d = DT_GUARD; state_d = ST_IGUARD;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_VGUARD, ST_IGUARD: begin
          if (is_guard_q) begin
            dtype_d = DT_GUARD;
            state_d = (state_q == ST_VGUARD) ? ST_VIDEO : ST_ISLAND;
            icnt_d  = 6'd0;
          end else begin
            err_d = 1'b1; ctl_out_s = is_ctrl_q; state_d = ST_CONTROL;
          end
        end
        ST_VIDEO: begin
          if (is_ctrl_q) begin
            ctl_out_s = 1'b1; state_d = ST_CONTROL;
          end else begin
            dtype_d = DT_PIX; data_d = pixel_decode(w_q);
          end
        end
        ST_ISLAND: begin
          if (is_ctrl_q) begin
            ctl_out_s = 1'b1; err_d = 1'b1; state_d = ST_CONTROL; icnt_d = 6'd0;
          end else begin
            dtype_d = DT_ISL;
            aux_d   = is_terc4_q ? nib_q : 4'h0;
            err_d   = ~is_terc4_q;
            if (icnt_q == ISL_LAST) begin
              state_d = ST_ITRAIL; icnt_d = 6'd0; tcnt_d = 2'd0;
            end else begin
              icnt_d = icnt_q + 6'd1;
            end
          end
        end
        ST_ITRAIL: begin
          if ((tcnt_q < 2'd2) && is_guard_q) begin
            dtype_d = DT_GUARD; tcnt_d = tcnt_q + 2'd1;
          end else if (is_ctrl_q) begin
            ctl_out_s = 1'b1; err_d = (tcnt_q < 2'd2); state_d = ST_CONTROL;
          end else begin
            err_d = 1'b1; state_d = ST_CONTROL;
          end
        end
        default: begin
          err_d = 1'b1; state_d = ST_CONTROL;
        end
      endcase
      // Preamble run: identical consecutive control codes, cleared by anything else
      if (ctl_out_s) begin
        ctl_d  = ctrl_code_q;
        last_d = ctrl_code_q;
        if (ctrl_code_q == last_q) begin
          run_d = (run_q == 5'd31) ? run_q : run_q + 5'd1;
        end else begin
          run_d = 5'd1;
        end
        ccnt_d = (ccnt_q == '1) ? ccnt_q : ccnt_q + LCNT_ONE;
      end else begin
        run_d  = 5'd0;
        ccnt_d = '0;
      end
      if (err_d) begin
        ecnt_d = (ecnt_q == '1) ? ecnt_q : ecnt_q + ECNT_ONE;
      end else begin
        ecnt_d = '0;
      end
      if (ecnt_d >= ERR_W) begin
        locked_d = 1'b0;
      end else if (ccnt_d >= LOCK_W) begin
        locked_d = 1'b1;
      end else begin
        locked_d = locked_q;
      end
    end else begin
      ctl_out_s = 1'b0;
    end
  end

  // Stage 2 registers: FSM state, counters and all outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_CONTROL; run_q <= 5'd0; last_q <= 2'b00; icnt_q <= 6'd0; tcnt_q <= 2'd0;
      dtype_q <= 2'b00; ctl_q <= 2'b00; aux_q <= 4'h0; data_q <= 8'h00; err_q <= 1'b0;
      ccnt_q <= '0; ecnt_q <= '0; locked_q <= 1'b0;
    end else begin
      state_q <= state_d; run_q <= run_d; last_q <= last_d; icnt_q <= icnt_d; tcnt_q <= tcnt_d;
      dtype_q <= dtype_d; ctl_q <= ctl_d; aux_q <= aux_d; data_q <= data_d; err_q <= err_d;
      ccnt_q <= ccnt_d; ecnt_q <= ecnt_d; locked_q <= locked_d;
    end
  end

  assign o_dtype  = dtype_q;
  assign o_ctl    = ctl_q;
  assign o_aux    = aux_q;
  assign o_data   = data_q;
  assign o_err    = err_q;
  assign o_locked = locked_q;

endmodule

// File: tb/tb_tmdsdecode.sv
// tb_tmdsdecode: directed HDMI period sequences followed by randomized segments,
// each output compared against a behavioural model of the decoder rules.
module tb_tmdsdecode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] i_word = 10'h000;
  logic [1:0] o_dtype, o_ctl;
  logic [3:0] o_aux;
  logic [7:0] o_data;
  logic       o_err, o_locked;

  tmdsdecode dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_word(i_word),
    .o_dtype(o_dtype), .o_ctl(o_ctl), .o_aux(o_aux), .o_data(o_data),
    .o_err(o_err), .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  // Words below are in decoder order (w); the bench reverses them onto i_word.
  localparam logic [9:0] GUARD_W = 10'h2CC;
  logic [9:0] ctl_tok [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  logic [9:0] terc     [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                                10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [17:0] exp_q [$];
  string       tag_q [$];

  // Behavioural model state
  int         m_phase;   // 0 control, 1 video leading guard, 2 video, 3 island leading guard, 4 island, 5 trailing guards
  int         m_run;
  logic [1:0] m_code;
  int         m_island, m_trail, m_ctl_streak, m_err_streak;
  bit         m_lock;

  function automatic logic [9:0] rev10(input logic [9:0] w);
    logic [9:0] r;
    for (int k = 0; k < 10; k++) r[k] = w[9 - k];
    return r;
  endfunction

  function automatic logic [7:0] pix(input logic [9:0] w);
    logic [7:0] q;
    q = w[9] ? ~w[7:0] : w[7:0];
    return (q ^ {q[6:0], 1'b0}) ^ (w[8] ? 8'h00 : 8'hFE);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_code = 2'b00; m_island = 0; m_trail = 0;
    m_ctl_streak = 0; m_err_streak = 0; m_lock = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] w, output logic [17:0] e);
    int ci, ti;
    bit g, er, co;
    logic [1:0] dt, ct;
    logic [3:0] ax;
    logic [7:0] dd;
    ci = -1; ti = -1;
    for (int i = 0; i < 4; i++) if (w == ctl_tok[i]) ci = i;
    for (int i = 0; i < 16; i++) if (w == terc[i]) ti = i;
    g = (w == GUARD_W);
    dt = 2'd1; ct = 2'd0; ax = 4'd0; dd = 8'd0; er = 1'b0; co = 1'b0;
    case (m_phase)
      0: begin
        if (ci >= 0) co = 1'b1;
        else if (g && m_run >= 8 && m_code == 2'b01) begin dt = 2'd0; m_phase = 1; end
        else if (g && m_run >= 8 && m_code == 2'b11) begin dt = 2'd0; m_phase = 3; end
        else er = 1'b1;
      end
      1, 3: begin
        if (g) begin dt = 2'd0; m_phase = m_phase + 1; m_island = 0; end
        else begin er = 1'b1; co = (ci >= 0); m_phase = 0; end
      end
      2: begin
        if (ci >= 0) begin co = 1'b1; m_phase = 0; end
        else begin dt = 2'd3; dd = pix(w); end
      end
      4: begin
        if (ci >= 0) begin co = 1'b1; er = 1'b1; m_phase = 0; end
        else begin
          dt = 2'd2;
          if (ti >= 0) ax = ti[3:0]; else er = 1'b1;
          m_island++;
          if (m_island == 32) begin m_phase = 5; m_trail = 0; end
        end
      end
      default: begin
        if (m_trail < 2 && g) begin dt = 2'd0; m_trail++; end
        else begin
          er = 1'b1;
          if (ci >= 0) begin co = 1'b1; er = (m_trail < 2); end
          m_phase = 0;
        end
      end
    endcase
    if (co) begin
      ct = ci[1:0];
      m_run  = (ci[1:0] == m_code) ? ((m_run < 31) ? m_run + 1 : 31) : 1;
      m_code = ci[1:0];
      m_ctl_streak++;
    end else begin
      m_run = 0;
      m_ctl_streak = 0;
    end
    m_err_streak = er ? m_err_streak + 1 : 0;
    if (m_err_streak >= 4) m_lock = 1'b0;
    else if (m_ctl_streak >= 16) m_lock = 1'b1;
    e = {dt, ct, ax, dd, er, m_lock};
  endtask

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_checks++;
    assert (obs === exp) begin n_pass++; end
    else begin
      n_fail++;
      $error("FAIL %s: observed dtype/ctl/aux/data/err/lock %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one word now, then after the next falling edge compare the output of the word sent two steps ago.
  task automatic send(input string tag, input logic [9:0] w);
    logic [17:0] e;
    model_step(w, e);
    i_word = rev10(w);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    if (exp_q.size() == 2) begin
      check(tag_q.pop_front(), {o_dtype, o_ctl, o_aux, o_data, o_err, o_locked}, exp_q.pop_front());
    end
  endtask

  task automatic send_n(input string tag, input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) send(tag, w);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset", {o_dtype, o_ctl, o_aux, o_data, o_err, o_locked}, 18'd0);
    rst_n = 1'b1;

    // Lock on 16 control tokens (input 0x0AB decodes as control 00)
    send_n("lock_ctl", rev10(10'h0AB), 16);
    // Video period
    send_n("vid_pre", 10'h0AB, 8);
    send_n("vid_guard", GUARD_W, 2);
    send("pixel_a", rev10(10'h002));
    send("pixel_b", rev10(10'h3FD));
    send("vid_end", 10'h354);
    // Data island period
    send_n("isl_pre", 10'h2AB, 8);
    send_n("isl_guard", GUARD_W, 2);
    send_n("isl_word", rev10(10'h0E5), 32);
    send_n("isl_trail", GUARD_W, 2);
    send("isl_end", 10'h354);
    // Short preamble
    send_n("short_pre", 10'h0AB, 7);
    send("short_guard", GUARD_W);
    send("ctl_garbage", 10'h100);
    // Lock kept by an intervening control token, then lost after four errors
    send_n("relock", 10'h354, 20);
    send_n("err3", 10'h100, 3);
    send("keep_lock", 10'h354);
    send_n("err4", 10'h100, 4);
    send_n("relock2", 10'h354, 16);
    // Asynchronous reset in the middle of a data island
    send_n("pre_rst", 10'h2AB, 8);
    send_n("pre_rst_g", GUARD_W, 2);
    send_n("pre_rst_isl", 10'h29C, 10);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {o_dtype, o_ctl, o_aux, o_data, o_err, o_locked}, 18'd0);
    exp_q.delete();
    tag_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send("post_rst", 10'h29C);
    send_n("post_rst_ctl", 10'h354, 3);

    // Randomized segments
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 4))
        0: send_n("rnd_ctl", ctl_tok[$urandom_range(0, 3)], $urandom_range(1, 12));
        1: begin
          send_n("rnd_vpre", 10'h0AB, $urandom_range(7, 10));
          send_n("rnd_vg", GUARD_W, $urandom_range(1, 3));
          for (int i = 0; i < $urandom_range(1, 20); i++) send("rnd_pix", 10'($urandom));
          send("rnd_vend", ctl_tok[$urandom_range(0, 3)]);
        end
        2: begin
          send_n("rnd_ipre", 10'h2AB, $urandom_range(7, 10));
          send_n("rnd_ig", GUARD_W, 2);
          for (int i = 0; i < 32; i++)
            send("rnd_isl", ($urandom_range(0, 19) == 0) ? 10'($urandom) : terc[$urandom_range(0, 15)]);
          send_n("rnd_it", GUARD_W, $urandom_range(1, 3));
          send("rnd_iend", ctl_tok[$urandom_range(0, 3)]);
        end
        3: for (int i = 0; i < $urandom_range(1, 5); i++) send("rnd_junk", 10'($urandom));
        default: begin
          send_n("rnd_spre", ctl_tok[$urandom_range(0, 3)], $urandom_range(1, 9));
          send("rnd_sg", GUARD_W);
        end
      endcase
    end
    send_n("flush", 10'h354, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
